// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache onto one single-ported RAM. The dcache has priority and keeps
// its grant for a whole block; a starvation counter eventually forces an icache grant.
module cache_mem_arbiter #(
    parameter int BURST_LEN    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ack,
    output logic        grant_d,
    output logic        grant_i
);
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_D = 2'd1,
        SERVE_I = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [BW-1:0] burst_cnt_r;
    logic [BW-1:0] burst_cnt_s;
    logic [SW-1:0] starve_cnt_r;
    logic [SW-1:0] starve_cnt_s;
    logic          dreq_s;
    logic          burst_end_s;

    assign dreq_s = dREN | dWEN;

    // Grant state and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            burst_cnt_r  <= '0;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_s;
            burst_cnt_r  <= burst_cnt_s;
            starve_cnt_r <= starve_cnt_s;
        end
    end

    // Next-state, burst tracking and starvation accounting
    always_comb begin
        state_s      = state_r;
        burst_cnt_s  = burst_cnt_r;
        starve_cnt_s = starve_cnt_r;
        burst_end_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (dreq_s && !(iREN && (starve_cnt_r == STARVE_MAX))) begin
                    state_s = SERVE_D;
                end else if (iREN) begin
                    state_s = SERVE_I;
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE_D: begin
                // A withdrawn request releases the grant even without an ack
                burst_end_s = !dreq_s || (ram_ack && (burst_cnt_r == BURST_LAST));
                if (burst_end_s) begin
                    burst_cnt_s = '0;
                    if (iREN) begin
                        if (starve_cnt_r != STARVE_MAX) begin
                            starve_cnt_s = starve_cnt_r + SW'(1);
                        end else begin
                            starve_cnt_s = starve_cnt_r;
                        end
                        state_s = SERVE_I;
                    end else begin
                        starve_cnt_s = '0;
                        state_s      = IDLE;
                    end
                end else begin
                    if (ram_ack) begin
                        burst_cnt_s = burst_cnt_r + BW'(1);
                    end else begin
                        burst_cnt_s = burst_cnt_r;
                    end
                    state_s = SERVE_D;
                end
            end
            SERVE_I: begin
                if (ram_ack || !iREN) begin
                    starve_cnt_s = '0;
                end else begin
                    starve_cnt_s = starve_cnt_r;
                end
                // One icache word per grant
                if (dreq_s) begin
                    state_s = SERVE_D;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // RAM-side muxing and cache handshakes from the registered grant
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = 32'h0;
        dload    = 32'h0;
        case (state_r)
            SERVE_D: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~ram_ack;
                if (ram_ack && dREN && !dWEN) begin
                    dload = ramload;
                end else begin
                    dload = 32'h0;
                end
            end
            SERVE_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~ram_ack;
                if (ram_ack) begin
                    iload = ramload;
                end else begin
                    iload = 32'h0;
                end
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign grant_d = (state_r == SERVE_D);
    assign grant_i = (state_r == SERVE_I);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed-vector bench for cache_mem_arbiter: a table of {inputs, expected outputs} records
// plus a hand-written starvation sequence.
module tb_cache_mem_arbiter;
    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ack;
    logic        grant_d;
    logic        grant_i;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        rst;
        logic        iren;
        logic        dren;
        logic        dwen;
        logic        ack;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] ds;
        logic [31:0] rl;
    } in_t;

    typedef struct packed {
        logic        gd;
        logic        gi;
        logic        rren;
        logic        rwen;
        logic        iwt;
        logic        dwt;
        logic [31:0] ra;
        logic [31:0] rs;
        logic [31:0] il;
        logic [31:0] dl;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    cache_mem_arbiter #(.BURST_LEN(2), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ack(ram_ack), .grant_d(grant_d), .grant_i(grant_i)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic in_t mi(input logic rst, input logic ir, input logic dr, input logic dw,
                               input logic ack, input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] ds, input logic [31:0] rl);
        in_t r;
        r.rst = rst; r.iren = ir; r.dren = dr; r.dwen = dw; r.ack = ack;
        r.ia = ia; r.da = da; r.ds = ds; r.rl = rl;
        return r;
    endfunction

    function automatic out_t o_idle();
        out_t r;
        r.gd = 1'b0; r.gi = 1'b0; r.rren = 1'b0; r.rwen = 1'b0; r.iwt = 1'b1; r.dwt = 1'b1;
        r.ra = 32'h0; r.rs = 32'h0; r.il = 32'h0; r.dl = 32'h0;
        return r;
    endfunction

    function automatic out_t od(input logic rr, input logic rw, input logic dwt,
                                input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] dl);
        out_t r;
        r.gd = 1'b1; r.gi = 1'b0; r.rren = rr; r.rwen = rw; r.iwt = 1'b1; r.dwt = dwt;
        r.ra = ra; r.rs = rs; r.il = 32'h0; r.dl = dl;
        return r;
    endfunction

    function automatic out_t oi(input logic rr, input logic iwt, input logic [31:0] ra,
                                input logic [31:0] il);
        out_t r;
        r.gd = 1'b0; r.gi = 1'b1; r.rren = rr; r.rwen = 1'b0; r.iwt = iwt; r.dwt = 1'b1;
        r.ra = ra; r.rs = 32'h0; r.il = il; r.dl = 32'h0;
        return r;
    endfunction

    function automatic vec_t mv(input in_t i, input out_t o);
        vec_t r;
        r.i = i;
        r.o = o;
        return r;
    endfunction

    task automatic apply(input string nm, input in_t v, input out_t e);
        out_t act;
        RST = v.rst; iREN = v.iren; dREN = v.dren; dWEN = v.dwen; ram_ack = v.ack;
        iaddr = v.ia; daddr = v.da; dstore = v.ds; ramload = v.rl;
        @(negedge CLK);
        act.gd = grant_d; act.gi = grant_i; act.rren = ramREN; act.rwen = ramWEN;
        act.iwt = iwait; act.dwt = dwait; act.ra = ramaddr; act.rs = ramstore;
        act.il = iload; act.dl = dload;
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got gd=%b gi=%b ren=%b wen=%b iw=%b dw=%b addr=%h st=%h il=%h dl=%h, expected gd=%b gi=%b ren=%b wen=%b iw=%b dw=%b addr=%h st=%h il=%h dl=%h",
                     nm, act.gd, act.gi, act.rren, act.rwen, act.iwt, act.dwt, act.ra, act.rs, act.il, act.dl,
                     e.gd, e.gi, e.rren, e.rwen, e.iwt, e.dwt, e.ra, e.rs, e.il, e.dl);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] sa;
        logic [31:0] si;
        logic [31:0] rl;

        // reset, idle
        tbl.push_back(mv(mi(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0), o_idle()));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0), o_idle()));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0), o_idle()));
        // single icache read
        tbl.push_back(mv(mi(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF), o_idle()));
        tbl.push_back(mv(mi(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF), oi(1'b1, 1'b0, 32'h40, 32'hDEADBEEF)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF), o_idle()));
        // dcache burst against a waiting icache
        tbl.push_back(mv(mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h100, 32'h0, 32'h11111111), o_idle()));
        tbl.push_back(mv(mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h100, 32'h0, 32'h11111111), od(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h11111111)));
        tbl.push_back(mv(mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h104, 32'h0, 32'h22222222), od(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h22222222)));
        tbl.push_back(mv(mi(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h104, 32'h0, 32'h33333333), oi(1'b1, 1'b0, 32'h80, 32'h33333333)));
        // write wins over read, slow ack, then withdrawal
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h3100, 32'h5, 32'h0), o_idle()));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h3100, 32'h5, 32'h0), od(1'b0, 1'b1, 1'b1, 32'h3100, 32'h5, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h3100, 32'h5, 32'h0), od(1'b0, 1'b1, 1'b1, 32'h3100, 32'h5, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h3100, 32'h5, 32'h0), od(1'b0, 1'b1, 1'b1, 32'h3100, 32'h5, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h3100, 32'h5, 32'h77777777), od(1'b0, 1'b1, 1'b0, 32'h3100, 32'h5, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h3100, 32'h5, 32'h0), od(1'b0, 1'b0, 1'b1, 32'h3100, 32'h5, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0), o_idle()));
        // reset in the middle of a burst clears the word count
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0), o_idle()));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 32'hA1), od(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hA1)));
        tbl.push_back(mv(mi(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0), od(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0), o_idle()));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 32'h0, 32'hA2), od(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hA2)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0), od(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h200, 32'h0, 32'h0), od(1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0)));
        tbl.push_back(mv(mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0), o_idle()));

        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ack = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i].i, tbl[i].o);
        end

        // Starvation: four bursts with iREN held and no icache ack, then forced icache grant
        sa = 32'h500;
        si = 32'h600;
        rl = 32'hC0DE0000;
        apply("starve_enter", mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, si, sa, 32'h0, rl), o_idle());
        for (int k = 1; k <= 4; k++) begin
            rl = 32'hC0DE0000 + 32'(k);
            apply($sformatf("starve_d%0d_w0", k), mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, si, sa, 32'h0, rl), od(1'b1, 1'b0, 1'b0, sa, 32'h0, rl));
            apply($sformatf("starve_d%0d_w1", k), mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, si, sa, 32'h0, rl), od(1'b1, 1'b0, 1'b0, sa, 32'h0, rl));
            apply($sformatf("starve_i%0d_noack", k), mi(1'b0, 1'b1, (k < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0, si, sa, 32'h0, rl), oi(1'b1, 1'b1, si, 32'h0));
        end
        rl = 32'hFACE0001;
        apply("starve_idle_forced", mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, si, sa, 32'h0, rl), o_idle());
        apply("starve_forced_i", mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, si, sa, 32'h0, rl), oi(1'b1, 1'b0, si, rl));
        apply("starve_after_w0", mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, si, sa, 32'h0, rl), od(1'b1, 1'b0, 1'b0, sa, 32'h0, rl));
        apply("starve_after_w1", mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, si, sa, 32'h0, rl), od(1'b1, 1'b0, 1'b0, sa, 32'h0, rl));
        apply("starve_after_i", mi(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, si, sa, 32'h0, rl), oi(1'b1, 1'b0, si, rl));
        apply("starve_cleared_idle", mi(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, si, sa, 32'h0, rl), o_idle());
        apply("starve_cleared_d", mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, si, sa, 32'h0, rl), od(1'b0, 1'b0, 1'b1, sa, 32'h0, 32'h0));
        apply("final_idle", mi(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0), o_idle());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits between the icache and dcache and the single-ported RAM, granting one requester at a time.
- The dcache has priority and holds its grant for a full block (BURST_LEN words), so writebacks and fills are never split.
- A starvation counter forces an icache grant after STARVE_LIMIT consecutive dcache bursts while the icache is waiting.
- RAM-side outputs and cache wait signals are combinational from the registered grant state.

Parameters:
BURST_LEN, 2, words per dcache block; dcache grant held for up to this many RAM acks
STARVE_LIMIT, 4, consecutive dcache bursts allowed while iREN pending before icache is forced

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
iREN  in  1  icache read request
iaddr  in  32  icache word address
iload  out  32  instruction data; ramload when granted to icache and ram_ack, else 0
iwait  out  1  low only in the cycle the icache access completes
dREN  in  1  dcache read request
dWEN  in  1  dcache write request; wins over dREN if both high
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dload  out  32  ramload when granted to dcache and ram_ack, else 0
dwait  out  1  low only in the cycle the dcache access completes
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completes current access this cycle
grant_d  out  1  state == SERVE_D
grant_i  out  1  state == SERVE_I

Behaviour:
- Reset: all state is cleared when RST is high at a rising edge.
  - State returns to IDLE; burst_cnt and starve_cnt go to 0.
  - Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0, grant_d=grant_i=0.
  - RST mid-access abandons the access immediately; there is no completion.
- States: IDLE, SERVE_D, SERVE_I.
- IDLE: no RAM strobes; both waits are 1.
  - If (dREN|dWEN) and !(iREN && starve_cnt==STARVE_LIMIT), go to SERVE_D.
  - Else if iREN, go to SERVE_I.
  - Else stay in IDLE.
- SERVE_D (combinational outputs):
  - ramWEN=dWEN; ramREN=dREN&!dWEN; ramaddr=daddr; ramstore=dstore.
  - dwait=!ram_ack; dload=ramload when ram_ack.
  - On ram_ack, burst_cnt increments.
  - Burst ends when burst_cnt reaches BURST_LEN-1 and ram_ack is high, or when dREN|dWEN drops (the grant is released even before an ack).
  - At burst end, burst_cnt goes to 0.
  - At burst end, if iREN is high, starve_cnt increments, saturating at STARVE_LIMIT; otherwise it clears.
  - At burst end the next state is SERVE_I if iREN is high, else IDLE.
  - Without a burst end, stay in SERVE_D.
- SERVE_I:
  - ramREN=iREN; ramaddr=iaddr; iwait=!ram_ack; iload=ramload when ram_ack.
  - On ram_ack, or if iREN drops: starve_cnt goes to 0.
  - Next state is SERVE_D if a dcache request is pending, else IDLE.
  - The icache gets exactly one word per grant.
- Latency: a request seen in IDLE at cycle n has its RAM strobe at n+1. With ram_ack tied high, wait is low at n+1.
  - Back-to-back words within a dcache burst have no idle cycle between them.
- Non-granted requester: its wait stays 1 and its load is 0. Its requests are never dropped; it is simply held off.
- Simultaneous dREN&dWEN: a write is performed; dload is still 0 on write completion.
- Address changes within a burst are passed through unchecked; the cache is responsible for block-contiguous addresses.
- Counter widths: burst_cnt is $clog2(BURST_LEN)+1 bits; starve_cnt is $clog2(STARVE_LIMIT)+1 bits. Neither may wrap.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then all requests 0 → ramREN=ramWEN=0, iwait=dwait=1, grant_d=grant_i=0 on every cycle.
- Single icache read: iREN=1, iaddr=0x40, ram_ack=1, ramload=0xDEADBEEF → grant_i next cycle, ramaddr=0x40, iwait=0, iload=0xDEADBEEF, then IDLE.
- Dcache burst vs icache contention: dREN=iREN=1, daddr=0x100 then 0x104, ram_ack=1 → two consecutive dcache words (dwait=0 twice, iwait=1 throughout), then SERVE_I with ramaddr=iaddr.
- Dcache write priority: dREN=dWEN=1, daddr=0x3100, dstore=0x5, ram_ack after 3 cycles → ramWEN=1, ramREN=0, dwait=1 for 3 cycles then 0 for 1 cycle.
- Starvation: dcache requests continuously with iREN held high → after 4 dcache bursts the next grant is SERVE_I, then starve_cnt returns to 0.
- Request withdrawn / reset mid-access: dREN drops before ram_ack → ramREN=0 the same cycle and IDLE next cycle. RST asserted in SERVE_D → IDLE with all outputs at reset values the next cycle.
